axi_burst_gen: RTL and testbench

- Parametrised AXI address-channel burst generator for the DMA engines.
- Accepts one transfer request (start address, beat count) and issues a sequence of INCR bursts on a generic AXI address channel (AR or AW).
- Each burst is capped by MAX_LEN beats and never crosses a 4 KB boundary.
- Generalises the fixed 2-bit ID / 32-bit address / 64-bit data AXI channel types to configurable widths and adds sequencing behaviour.

---
 rtl/axi_burst_gen.sv | 144 ++++++++++++++
 tb/tb_axi_burst_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axi_burst_gen.sv
// axi_burst_gen: splits one (address, beat count) transfer request into a
// sequence of AXI INCR address-channel bursts. Each burst is capped at
// MAX_LEN beats and never crosses a 4 KB page.
module axi_burst_gen #(
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_LEN = 16,
  parameter int BEATS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BEATS_W-1:0] req_beats,
  input  logic [ID_W-1:0]   req_id,
  output logic              AxVALID,
  input  logic              AxREADY,
  output logic [ID_W-1:0]   AxID,
  output logic [ADDR_W-1:0] AxADDR,
  output logic [7:0]        AxLEN,
  output logic [2:0]        AxSIZE,
  output logic [1:0]        AxBURST,
  output logic              AxLOCK,
  output logic [3:0]        AxCACHE,
  output logic [2:0]        AxPROT,
  output logic              busy,
  output logic              done
);

  // bytes-per-beat shift
  localparam int SZ = $clog2(DATA_W / 8);
  // burst arithmetic width: wide enough for the remaining count, for
  // MAX_LEN=256, and for the 4096-byte page distance
  localparam int W  = (BEATS_W > 13) ? BEATS_W : 13;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEATS_W-1:0]  rem_q, rem_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                req_ready_q, req_ready_d;
  logic                axvalid_q, axvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [W-1:0]        rem_w;
  logic [W-1:0]        b4k;
  logic [W-1:0]        b;

  // Size of the burst currently presented: min(rem, MAX_LEN, beats to 4 KB).
  // Derived only from registers so it is stable while AxVALID waits.
  always_comb begin
    rem_w = W'(rem_q);
    b4k   = W'((13'h1000 - {1'b0, addr_q[11:0]}) >> SZ);
    b     = rem_w;
    if (W'(MAX_LEN) < b) b = W'(MAX_LEN);
    if (b4k < b)         b = b4k;
  end

  // Next-state logic for the request/issue sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    id_d        = id_q;
    req_ready_d = req_ready_q;
    axvalid_d   = axvalid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr & ~ADDR_W'((1 << SZ) - 1);
          rem_d  = req_beats;
          id_d   = req_id;
          if (req_beats != '0) begin
            state_d     = ISSUE;
            req_ready_d = 1'b0;
            axvalid_d   = 1'b1;
            busy_d      = 1'b1;
          end else begin
            // empty transfer completes without touching the bus
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (AxREADY) begin
          addr_d = addr_q + (ADDR_W'(b) << SZ);
          rem_d  = rem_q - BEATS_W'(b);
          if (rem_w == b) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            axvalid_d   = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      id_q        <= '0;
      req_ready_q <= 1'b1;
      axvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      req_ready_q <= req_ready_d;
      axvalid_q   <= axvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign AxVALID   = axvalid_q;
  assign AxID      = id_q;
  assign AxADDR    = addr_q;
  // length is forced to 0 when idle so stale register contents never show
  assign AxLEN     = axvalid_q ? 8'(b - W'(1)) : 8'd0;
  assign AxSIZE    = 3'(SZ);
  assign AxBURST   = 2'b01;
  assign AxLOCK    = 1'b0;
  assign AxCACHE   = 4'b0000;
  assign AxPROT    = 3'b000;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_axi_burst_gen.sv
// Directed bench for axi_burst_gen with default parameters (64-bit data,
// MAX_LEN=16). Inputs change on the falling edge; outputs are checked there.
module tb_axi_burst_gen;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_beats;
  logic [1:0]  req_id;
  logic        AxVALID;
  logic        AxREADY;
  logic [1:0]  AxID;
  logic [31:0] AxADDR;
  logic [7:0]  AxLEN;
  logic [2:0]  AxSIZE;
  logic [1:0]  AxBURST;
  logic        AxLOCK;
  logic [3:0]  AxCACHE;
  logic [2:0]  AxPROT;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  axi_burst_gen dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_beats(req_beats), .req_id(req_id),
    .AxVALID(AxVALID), .AxREADY(AxREADY), .AxID(AxID), .AxADDR(AxADDR),
    .AxLEN(AxLEN), .AxSIZE(AxSIZE), .AxBURST(AxBURST), .AxLOCK(AxLOCK),
    .AxCACHE(AxCACHE), .AxPROT(AxPROT), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one cycle; returns at the falling edge after
  // acceptance (first burst visible there when beats != 0).
  task automatic send_req(input logic [31:0] a, input logic [15:0] n, input logic [1:0] id);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_beats = n; req_id = id;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_beats = '0; req_id = '0; AxREADY = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (AxVALID !== 1'b0) begin errors++; $display("FAIL reset_axvalid: got %b expected 0", AxVALID); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (AxADDR !== 32'h0 || AxLEN !== 8'h0 || AxID !== 2'h0) begin errors++; $display("FAIL reset_regs: got addr %h len %h id %h expected 0 0 0", AxADDR, AxLEN, AxID); end
    checks++; if ({AxSIZE, AxBURST, AxLOCK, AxCACHE, AxPROT} !== {3'd3, 2'b01, 1'b0, 4'h0, 3'h0}) begin errors++; $display("FAIL reset_consts: got size %h burst %h lock %b cache %h prot %h expected 3 1 0 0 0", AxSIZE, AxBURST, AxLOCK, AxCACHE, AxPROT); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    send_req(32'h100, 16'd8, 2'd2);
    checks++; if (AxVALID !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL single_status: got valid %b busy %b ready %b expected 1 1 0", AxVALID, busy, req_ready); end
    checks++; if (AxADDR !== 32'h100 || AxLEN !== 8'd7 || AxID !== 2'd2) begin errors++; $display("FAIL single_burst: got addr %h len %0d id %0d expected 100 7 2", AxADDR, AxLEN, AxID); end
    checks++; if (AxSIZE !== 3'd3 || AxBURST !== 2'b01) begin errors++; $display("FAIL single_consts: got size %0d burst %0d expected 3 1", AxSIZE, AxBURST); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || AxVALID !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL single_done: got done %b busy %b valid %b ready %b expected 1 0 0 1", done, busy, AxVALID, req_ready); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_split();
    logic [31:0] ea [3];
    logic [7:0]  el [3];
    ea[0] = 32'h000; ea[1] = 32'h080; ea[2] = 32'h100;
    el[0] = 8'd15;   el[1] = 8'd15;   el[2] = 8'd7;
    send_req(32'h0, 16'd40, 2'd1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (AxVALID !== 1'b1 || AxADDR !== ea[i] || AxLEN !== el[i]) begin errors++; $display("FAIL split_burst%0d: got valid %b addr %h len %0d expected 1 %h %0d", i, AxVALID, AxADDR, AxLEN, ea[i], el[i]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL split_early_done%0d: got %b expected 0", i, done); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1 || AxVALID !== 1'b0) begin errors++; $display("FAIL split_done: got done %b valid %b expected 1 0", done, AxVALID); end
  endtask

  task automatic test_4k();
    send_req(32'h0FF0, 16'd8, 2'd3);
    checks++; if (AxADDR !== 32'h0FF0 || AxLEN !== 8'd1) begin errors++; $display("FAIL cross4k_b1: got addr %h len %0d expected ff0 1", AxADDR, AxLEN); end
    @(negedge clk);
    checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h1000 || AxLEN !== 8'd5) begin errors++; $display("FAIL cross4k_b2: got valid %b addr %h len %0d expected 1 1000 5", AxVALID, AxADDR, AxLEN); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL cross4k_done: got %b expected 1", done); end
  endtask

  task automatic test_backpressure();
    AxREADY = 1'b0;
    send_req(32'h200, 16'd20, 2'd1);
    req_valid = 1'b1; req_addr = 32'hABC0; req_beats = 16'd3; req_id = 2'd0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h200 || AxLEN !== 8'd15 || AxID !== 2'd1) begin errors++; $display("FAIL bp_hold%0d: got valid %b addr %h len %0d id %0d expected 1 200 15 1", i, AxVALID, AxADDR, AxLEN, AxID); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    AxREADY = 1'b1;
    @(negedge clk);
    checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h280 || AxLEN !== 8'd3) begin errors++; $display("FAIL bp_b2: got valid %b addr %h len %0d expected 1 280 3", AxVALID, AxADDR, AxLEN); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_done: got done %b ready %b expected 1 1", done, req_ready); end
  endtask

  task automatic test_zero_misalign();
    send_req(32'h500, 16'd0, 2'd2);
    checks++; if (done !== 1'b1 || AxVALID !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL zero_len: got done %b valid %b busy %b ready %b expected 1 0 0 1", done, AxVALID, busy, req_ready); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || AxVALID !== 1'b0) begin errors++; $display("FAIL zero_after: got done %b valid %b expected 0 0", done, AxVALID); end
    send_req(32'h105, 16'd1, 2'd0);
    checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h100 || AxLEN !== 8'd0) begin errors++; $display("FAIL misalign: got valid %b addr %h len %0d expected 1 100 0", AxVALID, AxADDR, AxLEN); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL misalign_done: got %b expected 1", done); end
  endtask

  task automatic test_back_to_back();
    send_req(32'h40, 16'd4, 2'd1);
    @(negedge clk);
    checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_done: got done %b ready %b expected 1 1", done, req_ready); end
    req_valid = 1'b1; req_addr = 32'h800; req_beats = 16'd2; req_id = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h800 || AxLEN !== 8'd1 || AxID !== 2'd3) begin errors++; $display("FAIL b2b_burst: got valid %b addr %h len %0d id %0d expected 1 800 1 3", AxVALID, AxADDR, AxLEN, AxID); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    send_req(32'h0, 16'd40, 2'd2);
    @(negedge clk);
    checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h80) begin errors++; $display("FAIL rmid_pre: got valid %b addr %h expected 1 80", AxVALID, AxADDR); end
    rst = 1'b1;
    #1;
    checks++; if (AxVALID !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abort: got valid %b ready %b busy %b expected 0 1 0", AxVALID, req_ready, busy); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || AxVALID === 1'b1) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_quiet: got %0d active cycles expected 0", seen_done); end
    send_req(32'h3000, 16'd16, 2'd1);
    checks++; if (AxVALID !== 1'b1 || AxADDR !== 32'h3000 || AxLEN !== 8'd15 || AxID !== 2'd1) begin errors++; $display("FAIL rmid_fresh: got valid %b addr %h len %0d id %0d expected 1 3000 15 1", AxVALID, AxADDR, AxLEN, AxID); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_fresh_done: got %b expected 1", done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_4k();
    test_backpressure();
    test_zero_misalign();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
